// File: rtl/ro_pair_counter_edge.sv
// Version constant for the RO pair counter edge path.
// Per-oscillator counting lives in ro_edge_counter.
package ro_pair_counter_edge_pkg;
  localparam int RO_EDGE_VERSION = 1;
endpackage

// File: rtl/ro_puf_pkg.sv
// Shared types and constants for the RO PUF measurement front end.
// Holds the pair-counter FSM state type, synchroniser depth and default settle time.
package ro_puf_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    COUNT  = 2'd2,
    DONE   = 2'd3
  } ro_state_t;

  localparam int RO_SYNC_STAGES     = 2;
  localparam int RO_SETTLE_CYC_DEF  = 4;

endpackage

// File: rtl/ro_edge_counter.sv
// Per-oscillator synchroniser, rising-edge detector and edge counter.
// Ports: clk, rst_n, ro (async), clr, en -> count[CNT_W], ovf. Saturation: RO_CNT_SATURATE_EN.
module ro_edge_counter
  import ro_puf_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ro,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  logic [RO_SYNC_STAGES-1:0] sync_q;
  logic                      dly_q;
  logic                      rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[RO_SYNC_STAGES-2:0], ro};
      dly_q  <= sync_q[RO_SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[RO_SYNC_STAGES-1] & ~dly_q;

`ifdef RO_CNT_SATURATE_EN
  logic at_max;

  assign at_max = &count;

  // A would-be wrap leaves the count parked at all-ones and flags it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (en && rise) begin
      if (at_max) ovf <= 1'b1;
      else        count <= count + CNT_W'(1);
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && rise) begin
      count <= count + CNT_W'(1);
    end
  end

  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/ro_pair_counter.sv
// RO pair measurement: settle, count both oscillators over win_len cycles, pulse done.
// Ports: start, win_len, ro0/ro1 -> ro_en, busy, done, count0/1, ovf. Macro: RO_CNT_SATURATE_EN.
module ro_pair_counter
  import ro_puf_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int WIN_W      = 16,
  parameter int SETTLE_CYC = RO_SETTLE_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIN_W-1:0] win_len,
  input  logic             ro0,
  input  logic             ro1,
  output logic             ro_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count0,
  output logic [CNT_W-1:0] count1,
  output logic             ovf
);

  localparam int SW = $clog2(SETTLE_CYC);

  ro_state_t        state, state_nxt;
  logic [SW-1:0]    settle_cnt, settle_nxt;
  logic [WIN_W-1:0] win_cnt, win_nxt;
  logic             clr;
  logic             cnt_en;
  logic             ovf0, ovf1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      win_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
      win_cnt    <= win_nxt;
    end
  end

  // win_cnt holds the COUNT cycles still to run.
  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    win_nxt    = win_cnt;
    clr        = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt  = SETTLE;
          settle_nxt = SW'(SETTLE_CYC - 1);
          win_nxt    = win_len;
          clr        = 1'b1;
        end
      end
      SETTLE: begin
        if (settle_cnt == '0)
          state_nxt = (win_cnt == '0) ? DONE : COUNT;
        else
          settle_nxt = settle_cnt - SW'(1);
      end
      COUNT: begin
        win_nxt = win_cnt - WIN_W'(1);
        if (win_cnt == WIN_W'(1))
          state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign cnt_en = (state == COUNT);
  assign ro_en  = (state == SETTLE) | (state == COUNT);
  assign busy   = ro_en;
  assign done   = (state == DONE);
  assign ovf    = ovf0 | ovf1;

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt0 (
    .clk   (clk),
    .rst_n (rst_n),
    .ro    (ro0),
    .clr   (clr),
    .en    (cnt_en),
    .count (count0),
    .ovf   (ovf0)
  );

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt1 (
    .clk   (clk),
    .rst_n (rst_n),
    .ro    (ro1),
    .clr   (clr),
    .en    (cnt_en),
    .count (count1),
    .ovf   (ovf1)
  );

endmodule

// File: doc/ro_pair_counter.md
# ro_pair_counter

Measurement front end of the RO PUF: on a start request it enables one ring-oscillator pair, counts rising edges of each oscillator over a programmable window of system-clock cycles, then presents both counts with a done pulse. It produces the `count0`/`count1` pair consumed by the downstream winner comparator. All counting is done in the system clock domain after synchronising the oscillator outputs.

## Interface

- `CNT_W`, 32: width of each edge count.
- `WIN_W`, 16: width of the window-length input.
- `SETTLE_CYC`, 4: cycles between enabling the oscillators and opening the count window; must be ≥ 3 so the synchroniser pipeline fills.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  measurement request; accepted only in IDLE.
- `win_len`  in  WIN_W  window length in clk cycles; sampled when `start` is accepted.
- `ro0`, `ro1`  in  1 each  raw oscillator outputs, asynchronous to `clk`.
- `ro_en`  out  1  oscillator enable.
- `busy`  out  1  high from start acceptance until the done cycle.
- `done`  out  1  one-cycle pulse; counts are valid from this cycle on.
- `count0`, `count1`  out  CNT_W each  edge counts for `ro0` and `ro1`.
- `ovf`  out  1  counter saturated; only meaningful with the saturation feature.

## Operation

- Each oscillator input passes through a 2-flop synchroniser and a 1-flop delay. A rising edge is `sync & ~sync_d`.
- FSM states:
  - IDLE: `start` → SETTLE. Clears both counts and `ovf`, latches `win_len`, loads the settle counter.
  - SETTLE: lasts SETTLE_CYC cycles, then → COUNT. If the latched `win_len` is 0, → DONE instead.
  - COUNT: lasts exactly `win_len` cycles, then → DONE. An edge detected in any COUNT cycle increments that oscillator's count by 1.
  - DONE: lasts one cycle, then → IDLE.
- Outputs by state:
  - `ro_en` = 1 in SETTLE and COUNT, otherwise 0.
  - `busy` = 1 in SETTLE and COUNT.
  - `done` = 1 only in DONE.
- Counts hold their value from DONE until the next accepted `start`.
- `start` is ignored outside IDLE. A `start` held high re-triggers on the cycle after DONE.
- Edges outside COUNT are never counted.
- Input rate limit: an oscillator must have a period of at least 2 clk cycles. The design assumes external ROs are divided down to meet this; faster inputs alias.
- Reset, asynchronous at any point including mid-measurement: state = IDLE and all of the following = 0: `ro_en`, `busy`, `done`, `count0`, `count1`, `ovf`, synchroniser flops, and the window and settle counters.

## Timing

- `start` high in IDLE at cycle T gives:
  - SETTLE over T+1 … T+SETTLE_CYC.
  - COUNT over T+SETTLE_CYC+1 … T+SETTLE_CYC+`win_len`.
  - `done` at T+SETTLE_CYC+`win_len`+1.
- Start-to-done latency is SETTLE_CYC+`win_len`+1 cycles. With `win_len` = 0 it is SETTLE_CYC+1 cycles, and both counts are 0.
- An oscillator edge reaches the edge detector 3 cycles after it is sampled.
- Counts update registered, one cycle after the detected edge. The last COUNT cycle's increment is visible in DONE.

## Configuration

- `RO_CNT_SATURATE_EN` defined:
  - Each counter stops at all-ones instead of wrapping.
  - `ovf` is set the cycle either counter would pass all-ones and stays set until the next accepted `start` or reset.
- `RO_CNT_SATURATE_EN` undefined:
  - Counters wrap modulo 2^CNT_W.
  - `ovf` is tied to 0.

## Structure

- Package `ro_puf_pkg` holds:
  - the FSM state typedef (IDLE, SETTLE, COUNT, DONE);
  - `RO_SYNC_STAGES` = 2;
  - the default `SETTLE_CYC`.
- Sub-module `ro_edge_counter`, instantiated once per oscillator, contains:
  - the synchroniser and edge detector;
  - count clear/enable inputs and the count output;
  - the saturation logic and local overflow flag.

## Test plan

- **Basic count.** `ro0` period 4 clk, `ro1` period 6 clk, both driven synchronously to `clk`, `win_len` = 120, SETTLE_CYC = 4, `start` at T → `done` at T+125 with `count0` = 30, `count1` = 20, `busy` high T+1 … T+124, `ro_en` high T+1 … T+124.
- **Zero window.** `win_len` = 0 → `done` at T+5, counts 0, no increments even with both oscillators toggling.
- **Saturation.** CNT_W = 4, `ro0` period 4, `win_len` = 100:
  - with `RO_CNT_SATURATE_EN`: `count0` = 15, `ovf` = 1;
  - without it: `count0` = 9 (25 mod 16), `ovf` = 0.
- **Start while busy.** Pulse `start` again mid-COUNT → ignored, single `done`, counts unchanged versus the basic case. Holding `start` high → a new measurement begins the cycle after DONE and counts clear.
- **Reset mid-operation.** Assert `rst_n` low mid-COUNT → all outputs 0 immediately and state IDLE. A fresh start after release gives correct counts (30/20 stimulus).
- **Equal oscillators.** Both at period 8, `win_len` = 64 → `count0` = `count1` = 8. Counts hold through 50 idle cycles with the oscillators still toggling.
